pong_game_ctrl: RTL and testbench

Top-level game sequencer for the Pong display datapath. It counts balls remaining and score, times the pauses between rallies using the 60 Hz frame tick, and freezes or re-serves the graphics animator. It sits between the button inputs and the graphics/text generators. It consumes `hit`/`miss` pulses from the animator and drives its `gra_still` and `ball_reload` controls.

---
 rtl/pong_pkg.sv | 31 +++
 rtl/pong_bcd_counter2.sv | 61 ++++++
 rtl/pong_game_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// ----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the Pong game sequencer:
//   - state_t  : sequencer state codes (also driven out on the debug port)
//   - text_t   : message-select codes for the text generator
//   - LIVES_DEFAULT / PAUSE_TICKS_DEFAULT : default game parameters
//   - BCD_W    : width of one BCD score digit
//   - TIMER_W  : width of the pause timer (holds up to 127 frame ticks)
// ----------------------------------------------------------------------------
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    TXT_NONE  = 2'b00,
    TXT_START = 2'b01,
    TXT_READY = 2'b10,
    TXT_OVER  = 2'b11
  } text_t;

  localparam int LIVES_DEFAULT       = 3;
  localparam int PAUSE_TICKS_DEFAULT = 120;
  localparam int BCD_W               = 4;
  localparam int TIMER_W             = 7;

endpackage

// File: rtl/pong_bcd_counter2.sv
// ----------------------------------------------------------------------------
// pong_bcd_counter2
// Two-digit BCD up-counter. Each digit rolls 9 -> 0 and carries into the next;
// the tens digit rolls over too, so 99 + 1 gives 00.
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset, clears both digits
//   clr  in   synchronous clear (has priority over inc)
//   inc  in   add one this cycle
//   d1   out  tens digit
//   d0   out  units digit
// ----------------------------------------------------------------------------
module pong_bcd_counter2 (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  output logic [pong_pkg::BCD_W-1:0] d1,
  output logic [pong_pkg::BCD_W-1:0] d0
);
  import pong_pkg::*;

  localparam int NDIG = 2;

  // carry[i] is high when digit i steps this cycle
  logic [NDIG-1:0]            carry;
  logic [NDIG-1:0][BCD_W-1:0] digit;

  assign carry[0] = inc;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      logic [BCD_W-1:0] digit_reg;
      logic             at_nine;

      assign at_nine = (digit_reg == BCD_W'(9));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          digit_reg <= '0;
        end else if (clr) begin
          digit_reg <= '0;
        end else if (carry[gi]) begin
          digit_reg <= at_nine ? '0 : digit_reg + BCD_W'(1);
        end
      end

      assign digit[gi] = digit_reg;

      // The top digit simply wraps; only lower digits feed a carry onward.
      if (gi < NDIG - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] & at_nine;
      end
    end
  endgenerate

  assign d0 = digit[0];
  assign d1 = digit[1];

endmodule

// File: rtl/pong_game_ctrl.sv
// ----------------------------------------------------------------------------
// pong_game_ctrl
// Game sequencer for the Pong datapath: counts balls and score, times the
// pause after a miss / game over with the frame tick, and freezes or
// re-serves the graphics animator.
// Configuration macro: PONG_SCORE_EN -- when defined the BCD score counter is
// built; when undefined the score outputs are tied to 0 and hit is ignored.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   refr_tick    in   one-cycle pulse per frame
//   btn[1:0]     in   buttons, any bit set = serve/start
//   hit          in   ball bounced off paddle (pulse)
//   miss         in   ball passed paddle (pulse)
//   gra_still    out  freeze animator
//   ball_reload  out  one-cycle pulse on the first cycle of PLAY
//   text_sel     out  message select (none/start/ready/over)
//   balls_left   out  balls remaining including the one in play
//   score_d1/d0  out  BCD score, tens/units
//   state        out  current state code
// ----------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int LIVES       = pong_pkg::LIVES_DEFAULT,
  parameter int PAUSE_TICKS = pong_pkg::PAUSE_TICKS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       refr_tick,
  input  logic [1:0]                 btn,
  input  logic                       hit,
  input  logic                       miss,
  output logic                       gra_still,
  output logic                       ball_reload,
  output logic [1:0]                 text_sel,
  output logic [1:0]                 balls_left,
  output logic [pong_pkg::BCD_W-1:0] score_d1,
  output logic [pong_pkg::BCD_W-1:0] score_d0,
  output logic [1:0]                 state
);
  import pong_pkg::*;

  localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
  localparam logic [TIMER_W-1:0] PAUSE_INIT = TIMER_W'(PAUSE_TICKS);

  state_t             state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [1:0]         balls_left_reg, balls_left_next;
  logic               ball_reload_reg, ball_reload_next;
  logic               serve;
  logic               timer_zero;

  assign serve      = |btn;
  assign timer_zero = (timer_reg == '0);

  // -------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_NEWGAME;
    end else begin
      state_reg <= state_next;
    end
  end

  // ------------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_NEWGAME: if (serve) state_next = ST_PLAY;
      // balls_left of 1 here means this miss loses the last ball
      ST_PLAY:    if (miss) state_next = (balls_left_reg == 2'd1) ? ST_OVER : ST_NEWBALL;
      // Timer is checked, not a latched press: early presses are dropped
      ST_NEWBALL: if (timer_zero && serve) state_next = ST_PLAY;
      ST_OVER:    if (timer_zero) state_next = ST_NEWGAME;
      default:    state_next = ST_NEWGAME;
    endcase
  end

  // ---------------------------------------------------------- state decode
  always_comb begin
    gra_still = 1'b1;
    text_sel  = TXT_START;
    case (state_reg)
      ST_PLAY: begin
        gra_still = 1'b0;
        text_sel  = TXT_NONE;
      end
      ST_NEWBALL: text_sel = TXT_READY;
      ST_OVER:    text_sel = TXT_OVER;
      default:    ;
    endcase
  end

  // ----------------------------------------------------- datapath next values
  always_comb begin
    timer_next      = timer_reg;
    balls_left_next = balls_left_reg;
    case (state_reg)
      ST_NEWGAME: balls_left_next = LIVES_INIT;
      ST_PLAY: begin
        if (miss) begin
          balls_left_next = balls_left_reg - 2'd1;
          timer_next      = PAUSE_INIT;
        end
      end
      ST_NEWBALL: begin
        if (refr_tick && !timer_zero) timer_next = timer_reg - TIMER_W'(1);
      end
      ST_OVER: begin
        if (timer_zero) begin
          balls_left_next = LIVES_INIT;
        end else if (refr_tick) begin
          timer_next = timer_reg - TIMER_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered so the pulse lands on the first PLAY cycle and never depends
  // combinationally on btn.
  assign ball_reload_next = (state_next == ST_PLAY) && (state_reg != ST_PLAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_reg       <= '0;
      balls_left_reg  <= LIVES_INIT;
      ball_reload_reg <= 1'b0;
    end else begin
      timer_reg       <= timer_next;
      balls_left_reg  <= balls_left_next;
      ball_reload_reg <= ball_reload_next;
    end
  end

  // ------------------------------------------------------------------ score
`ifdef PONG_SCORE_EN
  logic score_clr;
  logic score_inc;

  // Cleared while waiting for a game and on the OVER -> NEWGAME step, so the
  // first NEWGAME cycle already shows 00. A miss in the same cycle wins.
  assign score_clr = (state_reg == ST_NEWGAME) || ((state_reg == ST_OVER) && timer_zero);
  assign score_inc = (state_reg == ST_PLAY) && hit && !miss;

  pong_bcd_counter2 u_score (
    .clk (clk),
    .rst (rst),
    .clr (score_clr),
    .inc (score_inc),
    .d1  (score_d1),
    .d0  (score_d0)
  );
`else
  logic unused_hit;
  assign unused_hit = hit;
  assign score_d1   = '0;
  assign score_d0   = '0;
`endif

  assign state       = state_reg;
  assign balls_left  = balls_left_reg;
  assign ball_reload = ball_reload_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pong_game_ctrl
// Drives directed and randomized stimulus into pong_game_ctrl. Each driven
// cycle advances a behavioural game model and queues the expected outputs;
// a monitor pops one expectation per clock and compares.
// ----------------------------------------------------------------------------
module tb_pong_game_ctrl;

  localparam int LIVES = 3;
  localparam int PAUSE = 120;
`ifdef PONG_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  // game modes as named by the display messages
  localparam int M_NEWGAME = 0;
  localparam int M_PLAY    = 1;
  localparam int M_NEWBALL = 2;
  localparam int M_OVER    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       refr_tick = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still, ball_reload;
  logic [1:0] text_sel, balls_left, state;
  logic [3:0] score_d1, score_d0;

  pong_game_ctrl #(.LIVES(LIVES), .PAUSE_TICKS(PAUSE)) dut (
    .clk         (clk),
    .rst         (rst),
    .refr_tick   (refr_tick),
    .btn         (btn),
    .hit         (hit),
    .miss        (miss),
    .gra_still   (gra_still),
    .ball_reload (ball_reload),
    .text_sel    (text_sel),
    .balls_left  (balls_left),
    .score_d1    (score_d1),
    .score_d0    (score_d0),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       gs;
    logic       br;
    logic [1:0] ts;
    logic [1:0] bl;
    logic [3:0] d1;
    logic [3:0] d0;
  } snap_t;

  snap_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  always @(posedge clk) cyc++;

  // ------------------------------------------------------ behavioural model
  int m_mode, m_score, m_lives, m_pause;
  bit m_reload;

  function automatic int txt_of(input int mode);
    case (mode)
      M_NEWGAME: return 1;
      M_PLAY:    return 0;
      M_NEWBALL: return 2;
      default:   return 3;
    endcase
  endfunction

  function automatic void model_step(input bit r, input logic [1:0] b, input bit h,
                                     input bit m, input bit t);
    bit served;
    served   = (b != 2'b00);
    m_reload = 1'b0;
    if (r) begin
      m_mode = M_NEWGAME; m_score = 0; m_lives = LIVES; m_pause = 0;
      return;
    end
    case (m_mode)
      M_NEWGAME: begin
        m_lives = LIVES;
        m_score = 0;
        if (served) begin m_mode = M_PLAY; m_reload = 1'b1; end
      end
      M_PLAY: begin
        if (m) begin
          m_lives = m_lives - 1;
          m_pause = PAUSE;
          m_mode  = (m_lives == 0) ? M_OVER : M_NEWBALL;
        end else if (h && SCORE_EN) begin
          m_score = (m_score + 1) % 100;
        end
      end
      M_NEWBALL: begin
        if (m_pause == 0 && served) begin m_mode = M_PLAY; m_reload = 1'b1; end
        else if (t && m_pause > 0) m_pause = m_pause - 1;
      end
      default: begin
        if (m_pause == 0) begin m_mode = M_NEWGAME; m_score = 0; m_lives = LIVES; end
        else if (t) m_pause = m_pause - 1;
      end
    endcase
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.st = 2'(m_mode);
    s.gs = (m_mode != M_PLAY);
    s.br = m_reload;
    s.ts = 2'(txt_of(m_mode));
    s.bl = 2'(m_lives);
    s.d1 = 4'(m_score / 10);
    s.d0 = 4'(m_score % 10);
    return s;
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic drive(input bit r, input logic [1:0] b, input bit h, input bit m, input bit t);
    @(negedge clk);
    rst = r; btn = b; hit = h; miss = m; refr_tick = t;
    model_step(r, b, h, m, t);
    exp_q.push_back(model_snap());
  endtask

  task automatic run_until(input int mode, input int max_cyc, input logic [1:0] b, input int tick_div);
    int k;
    k = 0;
    while (m_mode != mode && k < max_cyc) begin
      drive(1'b0, b, 1'b0, 1'b0, $urandom_range(0, tick_div - 1) == 0);
      k++;
    end
    n_vec++;
    if (m_mode != mode) begin
      n_bad++;
      $display("FAIL wait_mode: reached mode %0d after %0d cycles, required mode %0d", m_mode, k, mode);
    end
  endtask

  task automatic chk(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // --------------------------------------------------------------- monitor
  initial begin
    snap_t e, g;
    int last_mode;
    last_mode = -1;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {state, gra_still, ball_reload, text_sel, balls_left, score_d1, score_d0};
        n_vec++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d got st=%0d gs=%0d br=%0d ts=%0d bl=%0d score=%0d%0d required st=%0d gs=%0d br=%0d ts=%0d bl=%0d score=%0d%0d",
                   cyc, g.st, g.gs, g.br, g.ts, g.bl, g.d1, g.d0,
                   e.st, e.gs, e.br, e.ts, e.bl, e.d1, e.d0);
        end
        if (int'(e.st) != last_mode) begin
          $display("txn cyc=%0d state=%0d balls=%0d score=%0d%0d reload=%0d",
                   cyc, e.st, e.bl, e.d1, e.d0, e.br);
          last_mode = int'(e.st);
        end
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    int k;
    #1 rst = 1'b1;
    repeat (3) drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

    // start
    drive(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // 100 hits with random gaps: 09 -> 10 carry and 99 -> 00 wrap
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 1'b1, 1'b0, $urandom_range(0, 2) == 0);
      repeat ($urandom_range(0, 2)) drive(1'b0, 2'b00, 1'b0, 1'b0, $urandom_range(0, 2) == 0);
    end
    repeat (3) drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

    // hit and miss together: miss wins
    drive(1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
    // hit/miss/btn during pause are all ignored
    repeat (4) drive(1'b0, 2'b11, 1'b1, 1'b1, 1'b1);
    // hold button through the pause
    run_until(M_PLAY, 600, 2'b10, 2);

    // second miss, wait out the pause without button, then serve late
    repeat (5) drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    k = 0;
    while (m_pause > 0 && k < 600) begin
      drive(1'b0, 2'b00, 1'b0, 1'b0, $urandom_range(0, 1) == 0);
      k++;
    end
    repeat (3) drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);

    // last ball: game over, then back to NEWGAME
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    run_until(M_NEWGAME, 600, 2'b00, 2);
    repeat (3) drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    // random play
    for (int i = 0; i < 15000; i++) begin
      drive($urandom_range(0, 2999) == 0,
            ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 59) == 0,
            $urandom_range(0, 2) == 0);
    end

    // reset mid-play with score 42
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    repeat (42) drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    chk("midreset_state", int'(state), M_NEWGAME);
    chk("midreset_score", int'(score_d1) * 10 + int'(score_d0), 0);
    chk("midreset_reload", int'(ball_reload), 0);
    chk("midreset_balls", int'(balls_left), LIVES);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // drain
    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
